rom_sequencer: RTL and testbench

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/rom_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rom_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// Address sequencer for an external combinational table: free-run, manual, one-shot and ping-pong modes.
// Define ROM_SEQUENCER_PINGPONG_EN to build the bouncing mode 11; without it, mode 11 is free-run.
module rom_sequencer #(
  parameter int AW = 3,
  parameter int DW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] man_addr,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  input  logic [PW-1:0] div,
  input  logic          trig,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          busy,
  output logic          wrap
);
  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_MANUAL   = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;
  logic          addr_chg_q, addr_chg_d;
  logic          data_valid_q, data_valid_d;
  logic [1:0]    mode_q;
  mode_e         mode_sel;
  logic          tick, in_range, mode_chg;
  logic [AW-1:0] free_addr;
  logic          free_wrap;
`ifdef ROM_SEQUENCER_PINGPONG_EN
  logic          dir_dn_q, dir_dn_d;
`endif

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + 1'b1;
  endfunction

`ifdef ROM_SEQUENCER_PINGPONG_EN
  function automatic logic [AW-1:0] addr_dec(input logic [AW-1:0] a);
    return a - 1'b1;
  endfunction
`endif

  always_comb begin
    mode_sel = mode_e'(mode);
    mode_chg = (mode != mode_q);
    // >= keeps the prescaler from running past a freshly lowered div
    tick     = en && (presc_q >= div);
    in_range = (lo <= hi) && (rom_addr_q >= lo) && (rom_addr_q <= hi);

    free_addr = lo;
    free_wrap = 1'b0;
    if (in_range && (rom_addr_q == hi)) free_wrap = 1'b1;
    else if (in_range)                  free_addr = addr_inc(rom_addr_q);

    presc_d    = presc_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    wrap_d     = 1'b0;
`ifdef ROM_SEQUENCER_PINGPONG_EN
    dir_dn_d   = dir_dn_q;
`endif

    if (mode_chg) begin
      presc_d = '0;
      busy_d  = 1'b0;
`ifdef ROM_SEQUENCER_PINGPONG_EN
      dir_dn_d = 1'b0;
`endif
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      case (mode_sel)
        MODE_MANUAL: rom_addr_d = man_addr;
        MODE_ONESHOT: begin
          if (!busy_q) begin
            if (trig) begin
              rom_addr_d = lo;
              busy_d     = 1'b1;
            end
          end else if (tick) begin
            if (!in_range)               rom_addr_d = lo;
            else if (rom_addr_q == hi) begin
              busy_d = 1'b0;
              wrap_d = 1'b1;
            end else                     rom_addr_d = addr_inc(rom_addr_q);
          end
        end
`ifdef ROM_SEQUENCER_PINGPONG_EN
        MODE_PINGPONG: if (tick) begin
          if (!in_range) begin
            rom_addr_d = lo;
            dir_dn_d   = 1'b0;
          end else if (lo != hi) begin
            if (!dir_dn_q && (rom_addr_q == hi)) begin
              rom_addr_d = addr_dec(rom_addr_q);
              dir_dn_d   = 1'b1;
              wrap_d     = 1'b1;
            end else if (dir_dn_q && (rom_addr_q == lo)) begin
              rom_addr_d = addr_inc(rom_addr_q);
              dir_dn_d   = 1'b0;
              wrap_d     = 1'b1;
            end else if (dir_dn_q) rom_addr_d = addr_dec(rom_addr_q);
            else                   rom_addr_d = addr_inc(rom_addr_q);
          end
        end
`else
        MODE_PINGPONG: if (tick) begin
          rom_addr_d = free_addr;
          wrap_d     = free_wrap;
        end
`endif
        default: if (tick) begin
          rom_addr_d = free_addr;
          wrap_d     = free_wrap;
        end
      endcase
    end

    // data_out follows the address one cycle later, once the table has settled
    addr_chg_d   = (rom_addr_d != rom_addr_q);
    data_valid_d = addr_chg_q;
    data_out_d   = addr_chg_q ? rom_data : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      rom_addr_q   <= '0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
      wrap_q       <= 1'b0;
      addr_chg_q   <= 1'b0;
      data_valid_q <= 1'b0;
      mode_q       <= mode;
`ifdef ROM_SEQUENCER_PINGPONG_EN
      dir_dn_q     <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      rom_addr_q   <= rom_addr_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      wrap_q       <= wrap_d;
      addr_chg_q   <= addr_chg_d;
      data_valid_q <= data_valid_d;
      mode_q       <= mode;
`ifdef ROM_SEQUENCER_PINGPONG_EN
      dir_dn_q     <= dir_dn_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;
endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed scenarios plus randomized runs against a bounce/counter reference model.
module tb_rom_sequencer;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int PW = 8;
`ifdef ROM_SEQUENCER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk;
  logic          rst, en, trig;
  logic [1:0]    mode;
  logic [AW-1:0] man_addr, lo, hi, rom_addr;
  logic [PW-1:0] div;
  logic [DW-1:0] rom_data, data_out;
  logic          data_valid, busy, wrap;
  logic [DW-1:0] tbl [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  rom_sequencer #(.AW(AW), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .man_addr(man_addr),
    .lo(lo), .hi(hi), .div(div), .trig(trig), .rom_addr(rom_addr),
    .rom_data(rom_data), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .wrap(wrap)
  );

  assign rom_data = tbl[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (expected registered outputs after each edge)
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  bit            m_valid, m_chg, m_busy, m_wrap, m_up;
  int            m_cnt;
  logic [1:0]    m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int a, ilo, ihi, nxt;
    bit tick;
    logic [AW-1:0] n_addr;
    bit n_busy, n_up;
    if (rst) begin
      m_addr = '0; m_dout = '0; m_valid = 0; m_chg = 0; m_busy = 0;
      m_wrap = 0; m_up = 1; m_cnt = 0; m_mode = mode;
    end else begin
      m_valid = m_chg;
      if (m_chg) m_dout = tbl[m_addr];
      a = int'(m_addr); ilo = int'(lo); ihi = int'(hi);
      n_addr = m_addr; n_busy = m_busy; n_up = m_up; m_wrap = 0;
      if (mode != m_mode) begin
        m_cnt = 0; n_up = 1; n_busy = 0;
      end else if (en) begin
        tick  = (m_cnt == int'(div));
        m_cnt = tick ? 0 : m_cnt + 1;
        if (mode == 2'b01) n_addr = man_addr;
        else if (mode == 2'b10) begin
          if (!m_busy) begin
            if (trig) begin n_addr = lo; n_busy = 1; end
          end else if (tick) begin
            if (a < ilo || a > ihi) n_addr = lo;
            else if (a == ihi) begin n_busy = 0; m_wrap = 1; end
            else n_addr = AW'(a + 1);
          end
        end else if (tick) begin
          if (a < ilo || a > ihi) begin n_addr = lo; n_up = 1; end
          else if (PP && mode == 2'b11) begin
            if (ilo != ihi) begin
              nxt = m_up ? a + 1 : a - 1;
              if (nxt > ihi || nxt < ilo) begin
                n_up = !m_up; nxt = n_up ? a + 1 : a - 1; m_wrap = 1;
              end
              n_addr = AW'(nxt);
            end
          end else if (a == ihi) begin n_addr = lo; m_wrap = 1; end
          else n_addr = AW'((a + 1) % (1 << AW));
        end
      end
      m_chg = (n_addr != m_addr);
      m_addr = n_addr; m_busy = n_busy; m_up = n_up; m_mode = mode;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    int exp_a [5];
    int exp_w [5];
    int cnt;
    logic [AW-1:0] prev, t;
    for (int i = 0; i < (1 << AW); i++) tbl[i] = DW'($urandom);
    rst = 1; en = 1; trig = 0; mode = 2'b00; man_addr = '0; lo = 3'd2; hi = 3'd5; div = '0;

    // Reset state, then free-run lo=2 hi=5 div=0
    cycle(); cycle();
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_dout", 32'(data_out), 0);
    rst = 0;
    exp_a = '{2, 3, 4, 5, 2};
    exp_w = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("free_seq_addr", 32'(rom_addr), 32'(exp_a[i]));
      check("free_seq_wrap", 32'(wrap), 32'(exp_w[i]));
    end
    cycle();
    check("free_dout", 32'(data_out), 32'(tbl[2]));

    // Prescaled free-run: div=3 advances every 4 cycles
    rst = 1; div = 8'd3; cycle(); rst = 0;
    cnt = 0; prev = rom_addr;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (rom_addr != prev) cnt++;
      prev = rom_addr;
    end
    check("div3_changes", 32'(cnt), 4);

    // One-shot lo=1 hi=3, trig ignored while busy and on the terminal tick
    rst = 1; div = '0; mode = 2'b10; lo = 3'd1; hi = 3'd3; cycle(); rst = 0;
    cycle();
    check("os_idle_busy", 32'(busy), 0);
    trig = 1; cycle();
    check("os_start_addr", 32'(rom_addr), 1);
    check("os_start_busy", 32'(busy), 1);
    trig = 0; cycle();
    check("os_addr2", 32'(rom_addr), 2);
    trig = 1; cycle();
    check("os_addr3", 32'(rom_addr), 3);
    check("os_busy_run", 32'(busy), 1);
    cycle();
    check("os_end_addr", 32'(rom_addr), 3);
    check("os_end_busy", 32'(busy), 0);
    check("os_end_wrap", 32'(wrap), 1);
    trig = 0; cycle();
    check("os_after_wrap", 32'(wrap), 0);

    // Mode 11, lo=0 hi=2
    rst = 1; mode = 2'b11; lo = 3'd0; hi = 3'd2; cycle(); rst = 0;
    if (PP) begin exp_a = '{1, 2, 1, 0, 1}; exp_w = '{0, 0, 1, 0, 1}; end
    else    begin exp_a = '{1, 2, 0, 1, 2}; exp_w = '{0, 0, 1, 0, 0}; end
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("m11_addr", 32'(rom_addr), 32'(exp_a[i]));
      check("m11_wrap", 32'(wrap), 32'(exp_w[i]));
    end

    // Manual 7,7,4: two data_valid pulses
    rst = 1; mode = 2'b01; cycle(); rst = 0;
    cnt = 0;
    man_addr = 3'd7; cycle(); cnt += int'(data_valid);
    cycle(); cnt += int'(data_valid);
    man_addr = 3'd4;
    for (int i = 0; i < 4; i++) begin cycle(); cnt += int'(data_valid); end
    check("man_valid_cnt", 32'(cnt), 2);
    check("man_dout", 32'(data_out), 32'(tbl[4]));

    // Reset in the middle of a one-shot run
    mode = 2'b10; lo = 3'd0; hi = 3'd5; cycle();
    trig = 1; cycle(); trig = 0;
    cycle(); cycle();
    check("os_mid_addr", 32'(rom_addr), 2);
    rst = 1; cycle(); rst = 0;
    check("rst_mid_addr", 32'(rom_addr), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_dout", 32'(data_out), 0);
    check("rst_mid_valid", 32'(data_valid), 0);
    check("rst_mid_wrap", 32'(wrap), 0);

    // Randomized segments against the reference model
    for (int s = 0; s < 10; s++) begin
      rst = 1; mode = 2'($urandom_range(0, 3)); div = PW'($urandom_range(0, 3));
      lo = AW'($urandom); hi = AW'($urandom);
      if ($urandom_range(0, 3) != 0 && lo > hi) begin t = lo; lo = hi; hi = t; end
      trig = 0; en = 1;
      cycle();
      rst = 0;
      for (int c = 0; c < 80; c++) begin
        en = ($urandom_range(0, 9) != 0);
        trig = ($urandom_range(0, 5) == 0);
        man_addr = AW'($urandom);
        if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) begin lo = AW'($urandom); hi = AW'($urandom); end
        rst = ($urandom_range(0, 49) == 0);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
